// File: rtl/diff_vector_harness_if.sv
// Stimulus/response bus between the harness and the two DUT copies.
// stim goes out to golden and netlist; y_a/y_b come back for compare.
interface diff_vector_harness_if #(
  parameter int IN_W  = 52,
  parameter int OUT_W = 924
);
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] y_a;
  logic [OUT_W-1:0] y_b;

  modport master (
    output stim,
    input  y_a,
    input  y_b
  );

  modport slave (
    input  stim,
    output y_a,
    output y_b
  );
endinterface

// File: rtl/diff_vector_harness.sv
// Differential stimulus/compare harness: one LFSR vector per cycle into
// golden and netlist DUTs, cycle-wise compare, 32-bit stream signatures.
// Ports: clk, rst (async high), start pulse, dut bus (stim out, y_a/y_b
// in), busy, done, mismatch, first_mm_idx, mm_count, sig_a, sig_b.
// Build option: STOP_ON_MISMATCH_EN ends the run at the first differing
// sample (stim and signatures freeze, mm_count ends at 1).
module diff_vector_harness #(
  parameter int          IN_W    = 52,
  parameter int          OUT_W   = 924,
  parameter int          NUM_VEC = 21,
  parameter int          LAT     = 1,
  parameter logic [63:0] SEED    = 64'hACE1_0000_0000_0001,
  parameter int          CNT_W   = 8,
  localparam int         IDX_W   = $clog2(NUM_VEC + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  diff_vector_harness_if.master dut,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [IDX_W-1:0]  first_mm_idx,
  output logic [CNT_W-1:0]  mm_count,
  output logic [31:0]       sig_a,
  output logic [31:0]       sig_b
);

  localparam int CYC_W = $clog2(NUM_VEC + LAT + 2);
  localparam int NCH   = (OUT_W + 31) / 32;
  localparam int PW    = NCH * 32;
  localparam logic [63:0] SEED_EFF =
    (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZERO,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [63:0]      lfsr;
  logic [63:0]      lfsr_nx;
  logic [IN_W-1:0]  stim_q;
  logic [CYC_W-1:0] cyc;
  logic             samp;
  logic             differ;
  logic [IDX_W-1:0] sidx;

  function automatic logic [31:0] fold(
    input logic [OUT_W-1:0] y
  );
    logic [PW-1:0] p;
    logic [31:0]   r;
    p = PW'(y);
    r = '0;
    for (int i = 0; i < NCH; i++)
      r = r ^ p[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [31:0] crc(
    input logic [31:0] s,
    input logic [31:0] f
  );
    return {s[30:0], 1'b0}
         ^ (s[31] ? POLY : 32'd0)
         ^ f;
  endfunction

  // Fibonacci taps 64,63,61,60
  assign lfsr_nx = {lfsr[62:0],
    lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};

  assign busy = (state == S_ZERO)
             || (state == S_RUN)
             || (state == S_DRAIN);
  assign done = (state == S_DONE);

  assign dut.stim = stim_q;

  // cyc counts from 0 in ZERO; sample s lands on cycle s+LAT
  assign samp   = busy && (int'(cyc) >= LAT);
  assign differ = (dut.y_a != dut.y_b);
  assign sidx   = IDX_W'(int'(cyc) - LAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE,
      S_DONE:  if (start) state_d = S_ZERO;
      S_ZERO:  state_d = S_RUN;
      S_RUN:
        if (int'(cyc) == NUM_VEC)
          state_d = (LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN:
        if (int'(cyc) == NUM_VEC + LAT)
          state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
`ifdef STOP_ON_MISMATCH_EN
    if (samp && differ) state_d = S_DONE;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr         <= SEED_EFF;
      stim_q       <= '0;
      cyc          <= '0;
      mismatch     <= 1'b0;
      first_mm_idx <= '0;
      mm_count     <= '0;
      sig_a        <= '1;
      sig_b        <= '1;
    end else if (!busy) begin
      if (start) begin
        lfsr         <= SEED_EFF;
        stim_q       <= '0;
        cyc          <= '0;
        mismatch     <= 1'b0;
        first_mm_idx <= '0;
        mm_count     <= '0;
        sig_a        <= '1;
        sig_b        <= '1;
      end
    end else begin
      cyc <= cyc + CYC_W'(1);
      if (state == S_RUN)
        lfsr <= lfsr_nx;
      // entering RUN from ZERO shows the seed itself
      if (state_d == S_RUN)
        stim_q <= (state == S_ZERO) ?
          lfsr[IN_W-1:0] : lfsr_nx[IN_W-1:0];
      if (samp) begin
        sig_a <= crc(sig_a, fold(dut.y_a));
        sig_b <= crc(sig_b, fold(dut.y_b));
        if (differ) begin
          mismatch <= 1'b1;
          if (!mismatch)
            first_mm_idx <= sidx;
          if (mm_count != '1)
            mm_count <= mm_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_diff_vector_harness.sv
// Directed bench for diff_vector_harness: three parameter sets,
// table of run scenarios on the default build plus corner sequences.
module tb_diff_vector_harness;

`ifdef STOP_ON_MISMATCH_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic st0, st1, st2;
  int   checks = 0;
  int   errors = 0;

  // u0: defaults, y = registered {stim,~stim}
  diff_vector_harness_if #(.IN_W(52), .OUT_W(924)) if0();
  logic [923:0] ya0;
  logic         flip0;
  logic         busy0, done0, mm0;
  logic [4:0]   fi0;
  logic [7:0]   cnt0;
  logic [31:0]  sa0, sb0;
  always_ff @(posedge clk) ya0 <= 924'({if0.stim, ~if0.stim});
  assign if0.y_a = ya0;
  assign if0.y_b = ya0 ^ 924'(flip0);

  diff_vector_harness u0 (
    .clk(clk), .rst(rst), .start(st0), .dut(if0),
    .busy(busy0), .done(done0), .mismatch(mm0),
    .first_mm_idx(fi0), .mm_count(cnt0),
    .sig_a(sa0), .sig_b(sb0)
  );

  // u1: CNT_W=3, SEED=0, y_b always inverted
  diff_vector_harness_if #(.IN_W(8), .OUT_W(16)) if1();
  logic [15:0] ya1;
  logic        busy1, done1, mm1;
  logic [4:0]  fi1;
  logic [2:0]  cnt1;
  logic [31:0] sa1, sb1;
  always_ff @(posedge clk) ya1 <= {if1.stim, ~if1.stim};
  assign if1.y_a = ya1;
  assign if1.y_b = ~ya1;

  diff_vector_harness #(
    .IN_W(8), .OUT_W(16), .CNT_W(3), .SEED(64'd0)
  ) u1 (
    .clk(clk), .rst(rst), .start(st1), .dut(if1),
    .busy(busy1), .done(done1), .mismatch(mm1),
    .first_mm_idx(fi1), .mm_count(cnt1),
    .sig_a(sa1), .sig_b(sb1)
  );

  // u2: LAT=0, NUM_VEC=1, OUT_W=40, combinational DUT
  diff_vector_harness_if #(.IN_W(52), .OUT_W(40)) if2();
  logic        busy2, done2, mm2;
  logic [1:0]  fi2;
  logic [7:0]  cnt2;
  logic [31:0] sa2, sb2;
  assign if2.y_a = {~if2.stim[7:0], if2.stim[31:0]};
  assign if2.y_b = {~if2.stim[7:0], if2.stim[31:0]};

  diff_vector_harness #(
    .OUT_W(40), .NUM_VEC(1), .LAT(0)
  ) u2 (
    .clk(clk), .rst(rst), .start(st2), .dut(if2),
    .busy(busy2), .done(done2), .mismatch(mm2),
    .first_mm_idx(fi2), .mm_count(cnt2),
    .sig_a(sa2), .sig_b(sb2)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] adv(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  // bitwise fold: bit i lands in position i mod 32
  function automatic logic [31:0] bfold(input logic [1023:0] y);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 1024; i++) r[i%32] = r[i%32] ^ y[i];
    return r;
  endfunction

  function automatic logic [31:0] bcrc(input logic [31:0] s,
                                       input logic [31:0] f);
    logic [31:0] n;
    n = s << 1;
    if (s[31]) n = n ^ 32'h04C1_1DB7;
    return n ^ f;
  endfunction

  function automatic logic [31:0] model_sig(
    input logic [21:0] mask, input bit on);
    logic [63:0]   l;
    logic [51:0]   st;
    logic [1023:0] y;
    logic [31:0]   sg;
    l  = 64'hACE1_0000_0000_0001;
    sg = '1;
    for (int s = 0; s <= 21; s++) begin
      st = '0;
      if (s > 0) begin
        st = l[51:0];
        l  = adv(l);
      end
      y = 1024'({st, ~st});
      if (on && mask[s]) y[0] = ~y[0];
      sg = bcrc(sg, bfold(y));
      if (STOP && mask[s]) break;
    end
    return sg;
  endfunction

  // one run on u0; flips y_b bit0 in the cycle that carries sample s
  task automatic run0(input logic [21:0] mask, input int restart,
                      output int len, output logic [51:0] s0,
                      output logic [51:0] s1, output logic [51:0] s2);
    @(negedge clk);
    st0 = 1'b1;
    len = 0;
    s0 = 'x; s1 = 'x; s2 = 'x;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      len++;
      st0   = (c == restart);
      flip0 = (c >= 1 && c <= 22) ? mask[c-1] : 1'b0;
      if (c == 0) s0 = if0.stim;
      if (c == 1) s1 = if0.stim;
      if (c == 2) s2 = if0.stim;
      if (done0) break;
    end
    flip0 = 1'b0;
    st0   = 1'b0;
  endtask

  typedef struct {
    logic [21:0] mask;
    int          restart;
    logic        mm;
    int          first;
    int          cnt;
  } vec_t;

  vec_t        tbl[6];
  int          len;
  logic [51:0] s0, s1, s2;
  logic [7:0]  c1stim;
  int          ecnt, elen;

  initial begin
    tbl[0] = '{22'h0,      -1, 1'b0,  0, 0};
    tbl[1] = '{22'h20,     -1, 1'b1,  5, 1};
    tbl[2] = '{22'h1,      -1, 1'b1,  0, 1};
    tbl[3] = '{22'h200000, -1, 1'b1, 21, 1};
    tbl[4] = '{22'h288,    -1, 1'b1,  3, 3};
    tbl[5] = '{22'h0,       4, 1'b0,  0, 0};

    rst = 1'b1; st0 = 0; st1 = 0; st2 = 0; flip0 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stim", 64'(if0.stim), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_mm",   64'(mm0),   64'd0);
    chk("rst_fi",   64'(fi0),   64'd0);
    chk("rst_cnt",  64'(cnt0),  64'd0);
    chk("rst_sa",   64'(sa0),   64'hFFFF_FFFF);
    chk("rst_sb",   64'(sb0),   64'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run0(tbl[i].mask, tbl[i].restart, len, s0, s1, s2);
      ecnt = STOP ? int'(tbl[i].mm) : tbl[i].cnt;
      elen = (STOP && tbl[i].mm) ? tbl[i].first + 3 : 24;
      chk($sformatf("len%0d", i),   64'(len),   64'(elen));
      chk($sformatf("done%0d", i),  64'(done0), 64'd1);
      chk($sformatf("mm%0d", i),    64'(mm0),   64'(tbl[i].mm));
      chk($sformatf("fi%0d", i),    64'(fi0),   64'(tbl[i].first));
      chk($sformatf("cnt%0d", i),   64'(cnt0),  64'(ecnt));
      chk($sformatf("sa%0d", i),    64'(sa0),
          64'(model_sig(tbl[i].mask, 1'b0)));
      chk($sformatf("sb%0d", i),    64'(sb0),
          64'(model_sig(tbl[i].mask, 1'b1)));
      chk($sformatf("stim0_%0d", i), 64'(s0), 64'd0);
      chk($sformatf("stim1_%0d", i), 64'(s1),
          64'h1_0000_0000_0001);
      if (tbl[i].mask == 22'h0)
        chk($sformatf("stim2_%0d", i), 64'(s2),
            64'h2_0000_0000_0002);
      repeat (3) @(negedge clk);
      chk($sformatf("hold_sb%0d", i), 64'(sb0),
          64'(model_sig(tbl[i].mask, 1'b1)));
      chk($sformatf("hold_done%0d", i), 64'(done0), 64'd1);
    end

    // reset in the middle of a run that already saw a mismatch
    @(negedge clk);
    st0 = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      st0   = 1'b0;
      flip0 = (c == 6);
    end
    flip0 = 1'b0;
    chk("pre_rst_mm", 64'(mm0), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy0), 64'd0);
    chk("mid_rst_mm",   64'(mm0),   64'd0);
    chk("mid_rst_cnt",  64'(cnt0),  64'd0);
    chk("mid_rst_stim", 64'(if0.stim), 64'd0);
    chk("mid_rst_sb",   64'(sb0),   64'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;
    run0(22'h0, -1, len, s0, s1, s2);
    chk("post_rst_len", 64'(len), 64'd24);
    chk("post_rst_mm",  64'(mm0), 64'd0);
    chk("post_rst_sa",  64'(sa0), 64'(model_sig(22'h0, 1'b0)));
    chk("post_rst_sb",  64'(sb0), 64'(model_sig(22'h0, 1'b1)));

    // saturation with CNT_W=3 and zero seed
    @(negedge clk);
    st1 = 1'b1;
    len = 0;
    c1stim = 'x;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      len++;
      st1 = 1'b0;
      if (c == 1) c1stim = if1.stim;
      if (done1) break;
    end
    chk("u1_len",   64'(len),    STOP ? 64'd3 : 64'd24);
    chk("u1_stim1", 64'(c1stim), 64'd1);
    chk("u1_mm",    64'(mm1),    64'd1);
    chk("u1_fi",    64'(fi1),    64'd0);
    chk("u1_cnt",   64'(cnt1),   STOP ? 64'd1 : 64'd7);
    chk("u1_busy",  64'(busy1),  64'd0);
    chk("u1_sig_ne", 64'(sa1 != sb1), 64'd1);

    // LAT=0, single vector, 40-bit output folded as 32+8
    @(negedge clk);
    st2 = 1'b1;
    len = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      len++;
      st2 = 1'b0;
      if (done2) break;
    end
    chk("u2_len",  64'(len),   64'd3);
    chk("u2_mm",   64'(mm2),   64'd0);
    chk("u2_fi",   64'(fi2),   64'd0);
    chk("u2_cnt",  64'(cnt2),  64'd0);
    chk("u2_busy", 64'(busy2), 64'd0);
    chk("u2_sa",   64'(sa2),   64'hF2BC_D824);
    chk("u2_sb",   64'(sb2),   64'hF2BC_D824);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
